// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection from the EX-resolved
// redirect encoding, IF/ID pipeline register, and a saturating redirect counter.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        if_flush,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] jalr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic [15:0] redirect_cnt
);

    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] raw_target;
    logic        redirect;

    assign imem_addr = pc;
    assign redirect  = |npc_op;

    // JALR wins over JUMP/BRANCH; those two share the same pc-relative target.
    always_comb begin
        raw_target = br_pc + br_imm;
        if (npc_op[2])
            raw_target = jalr_target;
        target = {raw_target[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= target;
        else if (!stall)
            pc <= pc + 32'd4;
    end

    // A redirect squashes the wrong-path fetch even while stalled.
    always_ff @(posedge clk) begin
        if (rst || if_flush || redirect) begin
            id_pc    <= 32'h0;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_pc    <= pc;
            id_instr <= imem_rdata;
            id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            redirect_cnt <= 16'h0;
        else if (redirect && redirect_cnt != 16'hFFFF)
            redirect_cnt <= redirect_cnt + 16'd1;
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, random run against a reference
// model, and counter saturation / reset corner sequences.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, if_flush;
    logic [2:0]  npc_op;
    logic [31:0] br_pc, br_imm, jalr_target;
    logic [31:0] imem_addr, imem_rdata, id_pc, id_instr;
    logic        id_valid;
    logic [15:0] redirect_cnt;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .if_flush(if_flush),
        .br_pc(br_pc), .br_imm(br_imm), .jalr_target(jalr_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid),
        .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // instruction memory: address-derived words
    assign imem_rdata = word(imem_addr);

    typedef struct {
        logic        rst, stall, flush;
        logic [2:0]  op;
        logic [31:0] bpc, bimm, jalr;
        logic [31:0] e_pc, e_idpc;
        logic        e_v;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [2:0] op,
                                input logic [31:0] bpc, input logic [31:0] bimm, input logic [31:0] jalr,
                                input logic [31:0] e_pc, input logic [31:0] e_idpc, input logic e_v,
                                input logic [15:0] e_cnt);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.op = op;
        v.bpc = bpc; v.bimm = bimm; v.jalr = jalr;
        v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_v = e_v; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [2:0] op,
                         input logic [31:0] bpc, input logic [31:0] bimm, input logic [31:0] jalr);
        rst = r; stall = s; if_flush = f; npc_op = op;
        br_pc = bpc; br_imm = bimm; jalr_target = jalr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                             input logic e_v, input logic [31:0] e_instr, input logic [15:0] e_cnt);
        chk({tag, ".imem_addr"}, imem_addr, e_pc);
        chk({tag, ".id_pc"}, id_pc, e_idpc);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, e_v});
        chk({tag, ".id_instr"}, id_instr, e_instr);
        chk({tag, ".redirect_cnt"}, {16'b0, redirect_cnt}, {16'b0, e_cnt});
    endtask

    // reference model state
    logic [31:0] m_pc, m_idpc, m_instr;
    logic        m_v;
    int          m_cnt;

    task automatic model_step(input logic r, input logic s, input logic f, input logic [2:0] op,
                              input logic [31:0] bpc, input logic [31:0] bimm, input logic [31:0] jalr);
        logic [31:0] tgt;
        logic        redir;
        redir = (op != 3'b000);
        if (op[2]) tgt = jalr & 32'hFFFF_FFFC;
        else       tgt = (bpc + bimm) & 32'hFFFF_FFFC;
        if (r) begin
            m_pc = 0; m_idpc = 0; m_instr = NOP; m_v = 0; m_cnt = 0;
        end else begin
            if (redir || f) begin
                m_idpc = 0; m_instr = NOP; m_v = 0;
            end else if (!s) begin
                m_idpc = m_pc; m_instr = word(m_pc); m_v = 1;
            end
            if (redir) begin
                m_pc = tgt;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            end else if (!s) begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    initial begin
        rst = 1; stall = 0; if_flush = 0; npc_op = 0; br_pc = 0; br_imm = 0; jalr_target = 0;

        //          rst stl fl op      br_pc         br_imm        jalr          e_pc          e_idpc        v  cnt
        tbl.push_back(mk(1, 0, 0, 3'b000, 0,            0,            0,            32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h4,        32'h0,        1, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h8,        32'h4,        1, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'hC,        32'h8,        1, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h10,       32'hC,        1, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000, 0,            0,            0,            32'h10,       32'hC,        1, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000, 0,            0,            0,            32'h10,       32'hC,        1, 0));
        tbl.push_back(mk(0, 1, 0, 3'b000, 0,            0,            0,            32'h10,       32'hC,        1, 0));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h14,       32'h10,       1, 0));
        tbl.push_back(mk(0, 0, 0, 3'b001, 32'h20,       32'hFFFF_FFF0, 0,           32'h10,       32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h14,       32'h10,       1, 1));
        tbl.push_back(mk(0, 0, 0, 3'b100, 0,            0,            32'h103,      32'h100,      32'h0,        0, 2));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h104,      32'h100,      1, 2));
        tbl.push_back(mk(0, 1, 0, 3'b010, 32'h40,       32'h8,        0,            32'h48,       32'h0,        0, 3));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h4C,       32'h48,       1, 3));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h50,       32'h4C,       1, 3));
        tbl.push_back(mk(0, 0, 1, 3'b000, 0,            0,            0,            32'h54,       32'h0,        0, 3));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h58,       32'h54,       1, 3));
        tbl.push_back(mk(0, 0, 0, 3'b100, 0,            0,            32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0,      0, 4));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h0,        32'hFFFF_FFFC, 1, 4));
        tbl.push_back(mk(0, 0, 0, 3'b110, 32'h40,       32'h0,        32'h203,      32'h200,      32'h0,        0, 5));
        tbl.push_back(mk(0, 1, 1, 3'b000, 0,            0,            0,            32'h200,      32'h0,        0, 5));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h204,      32'h200,      1, 5));
        tbl.push_back(mk(0, 1, 0, 3'b000, 0,            0,            0,            32'h204,      32'h200,      1, 5));
        tbl.push_back(mk(1, 1, 1, 3'b001, 32'h80,       32'h4,        0,            32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 3'b011, 32'h1001,     32'h2,        0,            32'h1000,     32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 0, 3'b000, 0,            0,            0,            32'h1004,     32'h1000,     1, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].op, tbl[i].bpc, tbl[i].bimm, tbl[i].jalr);
            check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_idpc, tbl[i].e_v,
                      tbl[i].e_v ? word(tbl[i].e_idpc) : NOP, tbl[i].e_cnt);
        end

        // randomized run against the model
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic r, s, f;
            logic [2:0] op;
            logic [31:0] bpc, bimm, jalr;
            r    = ($urandom_range(0, 99) < 3);
            s    = ($urandom_range(0, 99) < 25);
            f    = ($urandom_range(0, 99) < 15);
            op   = ($urandom_range(0, 99) < 60) ? 3'b000 : 3'($urandom_range(1, 7));
            bpc  = $urandom;
            bimm = $urandom;
            jalr = $urandom;
            drive(r, s, f, op, bpc, bimm, jalr);
            model_step(r, s, f, op, bpc, bimm, jalr);
            check_all($sformatf("rnd%0d", i), m_pc, m_idpc, m_v, m_instr, 16'(m_cnt));
        end

        // counter saturation
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 70000; i++) begin
            drive(0, 0, 0, 3'b001, 32'h100, 32'h0, 0);
            if (i == 65534) chk("sat.pre", {16'b0, redirect_cnt}, 32'h0000_FFFE);
            if (i == 65535) chk("sat.hit", {16'b0, redirect_cnt}, 32'h0000_FFFF);
        end
        chk("sat.hold", {16'b0, redirect_cnt}, 32'h0000_FFFF);
        chk("sat.pc", imem_addr, 32'h100);

        // reset in the middle of a stall
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0);
        check_all("stall", 32'h108, 32'h104, 1, word(32'h104), 16'hFFFF);
        drive(1, 1, 0, 0, 0, 0, 0);
        check_all("rst_stall", 32'h0, 32'h0, 0, NOP, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, selects the next PC from the redirect encoding produced by the main decoder, drives the combinational instruction-memory address, and holds the IF/ID pipeline register with stall and flush control. Sits directly upstream of decode and consumes the decoder's NPCOp and IFflush outputs after they are resolved in EX. It also keeps a saturating redirect counter for performance debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID on flush/reset

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- stall  in  1  hazard-unit hold; freezes PC and IF/ID
- npc_op  in  3  next-PC op: 000 PLUS4, 001 BRANCH (taken), 010 JUMP (jal), 100 JALR
- if_flush  in  1  bubble IF/ID this edge
- br_pc  in  32  PC of the redirecting instruction (EX stage)
- br_imm  in  32  sign-extended B/J offset for that instruction
- jalr_target  in  32  rs1+imm from the ALU
- imem_addr  out  32  instruction-memory byte address (= pc)
- imem_rdata  in  32  instruction word at imem_addr, combinational, same cycle
- id_pc  out  32  PC of instruction in IF/ID
- id_instr  out  32  instruction in IF/ID
- id_valid  out  1  IF/ID holds a real instruction
- redirect_cnt  out  16  count of redirect cycles, saturating

## Operation
- pc register; imem_addr = pc continuously.
- Redirect = npc_op != 000. Target when redirect, priority JALR > JUMP > BRANCH if several bits set:
  - JALR: jalr_target with bit0 cleared.
  - JUMP / BRANCH: br_pc + br_imm, 32-bit modular add.
  - All targets then have bits[1:0] forced to 00 (no misalignment trap in this core).
- Next pc priority: rst -> RESET_PC; redirect -> target; stall -> hold; else pc + 4 (modular, 0xFFFF_FFFC -> 0x0000_0000).
- Redirect overrides stall (the stalled instruction is on the wrong path).
- IF/ID priority: rst -> {id_pc=0, id_instr=NOP_INSTR, id_valid=0}; if_flush or redirect -> same bubble values; stall -> hold all three; else load {pc, imem_rdata, 1}.
- if_flush without redirect: bubble IF/ID, pc still advances (pc+4, or hold if stall).
- redirect_cnt: reset 0; +1 on each non-reset cycle with redirect; sticks at 16'hFFFF.
- No other state; no FSM beyond PC/IF-ID/counter registers.

## Timing
- Reset values: pc=RESET_PC (imem_addr=RESET_PC), id_pc=0, id_instr=NOP_INSTR, id_valid=0, redirect_cnt=0.
- rst asserted mid-stream overrides stall, redirect and flush on that edge.
- Fetch latency: word at address A appears on id_instr/id_pc one edge after pc=A (no stall).
- Redirect: npc_op sampled at edge N; pc=target after N; target instruction in IF/ID after N+1; IF/ID is a bubble after N. Sequential fetches flushed: exactly the one in IF plus ID as flushed by the decode side.
- Stall for k cycles: pc, id_pc, id_instr, id_valid unchanged for k edges; resume next edge with stall low.
- All outputs registered except imem_addr (direct from pc register).

## Test plan
- Reset then 4 free-running cycles, imem returns addr-derived words -> imem_addr 0,4,8,12; id_pc 0,4,8 with id_valid=1 from the 2nd edge; id_instr=NOP_INSTR, id_valid=0 before.
- stall high 3 cycles at pc=0x10 -> pc, id_pc=0x0C, id_instr frozen 3 edges; pc=0x14 one edge after release.
- npc_op=001, br_pc=0x20, br_imm=0xFFFF_FFF0 -> pc=0x10 next edge, IF/ID bubble (id_valid=0), redirect_cnt+1; npc_op=100 with jalr_target=0x103 -> pc=0x100.
- Simultaneous stall=1 and npc_op=010, br_pc=0x40, br_imm=8 -> pc=0x48, IF/ID bubble (redirect beats stall); if_flush alone at pc=0x50 -> bubble, pc=0x54.
- pc forced to 0xFFFF_FFFC via JALR -> next pc 0x0000_0000; npc_op=110 -> JALR target used.
- 70000 redirect cycles -> redirect_cnt=16'hFFFF held; rst mid-stall -> all outputs at reset values next edge.
